word_packer: RTL and testbench

//   Downstream consumer of the shift_reg delay line. Gathers Depth consecutive

---
 rtl/word_packer.sv | 87 ++++++++
 tb/tb_word_packer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/word_packer.sv
// Collects Depth Width-bit words from a valid/ready stream into one packed frame.
// Define WORD_PACKER_MSB_FIRST_EN to place the first word in the top bits of d_o.
module word_packer #(
    parameter int Width = 32,
    parameter int Depth = 8,
    localparam int CntW = $clog2(Depth + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [Width-1:0]         d_i,
    input  logic                     flush_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [Width*Depth-1:0]   d_o,
    output logic [CntW-1:0]          cnt_o
);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]                  state;
    logic [CntW-1:0]             wr_ptr;
    logic [CntW-1:0]             cnt_q;
    logic [Depth-1:0][Width-1:0] slots;
    logic                        acc;
    logic                        drn;

    // In HOLD the input side follows the sink so a drain and a refill share a cycle.
    assign ready_o = (state == FILL) ? 1'b1 : ready_i;
    assign valid_o = (state == HOLD);
    assign cnt_o   = cnt_q;
    assign acc     = valid_i & ready_o;
    assign drn     = valid_o & ready_i;

    for (genvar k = 0; k < Depth; k++) begin : g_slot
`ifdef WORD_PACKER_MSB_FIRST_EN
        assign d_o[(Depth-1-k)*Width +: Width] = slots[k];
`else
        assign d_o[k*Width +: Width] = slots[k];
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= FILL;
            wr_ptr <= '0;
            cnt_q  <= '0;
            slots  <= '0;
        end else if (state == FILL) begin
            if (acc) begin
                for (int k = 0; k < Depth; k++) begin
                    if (wr_ptr == CntW'(k)) slots[k] <= d_i;
                end
                // A full frame wins over a coincident flush: no extra frame.
                if (wr_ptr == CntW'(Depth - 1)) begin
                    state  <= HOLD;
                    cnt_q  <= CntW'(Depth);
                    wr_ptr <= '0;
                end else if (flush_i) begin
                    state  <= HOLD;
                    cnt_q  <= wr_ptr + CntW'(1);
                    wr_ptr <= '0;
                end else begin
                    wr_ptr <= wr_ptr + CntW'(1);
                end
            end else if (flush_i && wr_ptr != '0) begin
                state  <= HOLD;
                cnt_q  <= wr_ptr;
                wr_ptr <= '0;
            end
        end else if (drn) begin
            // Clearing on drain keeps unused slots of a later partial frame at zero.
            state <= FILL;
            cnt_q <= '0;
            slots <= '0;
            if (acc) begin
                slots[0] <= d_i;
                wr_ptr   <= CntW'(1);
            end else begin
                wr_ptr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_word_packer.sv
// Scoreboard bench for word_packer: frames expected by each scenario are queued
// up front and checked by a monitor whenever the sink drains a frame.
module tb_word_packer;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int CW = 4;

    typedef struct {
        logic [W*D-1:0] d;
        logic [CW-1:0]  c;
    } frame_t;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           valid_i = 1'b0;
    logic           ready_o;
    logic [W-1:0]   d_i = '0;
    logic           flush_i = 1'b0;
    logic           valid_o;
    logic           ready_i = 1'b0;
    logic [W*D-1:0] d_o;
    logic [CW-1:0]  cnt_o;

    int     checks = 0;
    int     errs   = 0;
    frame_t q[$];

    word_packer #(.Width(W), .Depth(D)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .d_i(d_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
        .d_o(d_o), .cnt_o(cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected frame of n consecutive words starting at base.
    function automatic logic [W*D-1:0] pack(input logic [W-1:0] base, input int n);
        logic [W*D-1:0] f;
        f = '0;
        for (int k = 0; k < n; k++) begin
`ifdef WORD_PACKER_MSB_FIRST_EN
            f[(D-1-k)*W +: W] = base + W'(k);
`else
            f[k*W +: W] = base + W'(k);
`endif
        end
        return f;
    endfunction

    function automatic frame_t mk(input logic [W-1:0] base, input int n);
        frame_t fr;
        fr.d = pack(base, n);
        fr.c = CW'(n);
        return fr;
    endfunction

    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i) begin
            checks++;
            if (q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_frame d_o=%h cnt_o=%0d", d_o, cnt_o);
            end else begin
                frame_t e;
                e = q.pop_front();
                if (d_o !== e.d || cnt_o !== e.c) begin
                    errs++;
                    $display("FAIL frame_data got d_o=%h cnt=%0d exp d_o=%h cnt=%0d",
                             d_o, cnt_o, e.d, e.c);
                end
            end
        end
    end

    task automatic send_word(input logic [W-1:0] w, input logic f);
        bit ok;
        int n;
        ok = 0; n = 0;
        valid_i = 1'b1; d_i = w; flush_i = f;
        while (!ok && n < 50) begin
            @(negedge clk_i);
            ok = ready_o;
            @(posedge clk_i); #1;
            n++;
        end
        valid_i = 1'b0; flush_i = 1'b0;
        if (!ok) begin
            checks++; errs++;
            $display("FAIL send_timeout word=%h ready_o never high", w);
        end
    endtask

    task automatic send_run(input logic [W-1:0] base, input int n);
        for (int k = 0; k < n; k++) send_word(base + W'(k), 1'b0);
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++; errs++;
            $display("FAIL drain_timeout pending=%0d exp 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checks += 4;
        if (valid_o !== 1'b0) begin errs++; $display("FAIL reset_valid got %b exp 0", valid_o); end
        if (ready_o !== 1'b1) begin errs++; $display("FAIL reset_ready got %b exp 1", ready_o); end
        if (cnt_o !== '0)     begin errs++; $display("FAIL reset_cnt got %0d exp 0", cnt_o); end
        if (d_o !== '0)       begin errs++; $display("FAIL reset_data got %h exp 0", d_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_full_frame();
        ready_i = 1'b1;
        q.push_back(mk(32'd1, 8));
        send_run(32'd1, 8);
        checks += 2;
        if (valid_o !== 1'b1) begin errs++; $display("FAIL full_latency valid_o got %b exp 1", valid_o); end
        if (cnt_o !== 4'd8)   begin errs++; $display("FAIL full_cnt got %0d exp 8", cnt_o); end
        wait_drained();
    endtask

    task automatic test_backpressure();
        logic [W*D-1:0] held;
        held = pack(32'h21, 8);
        ready_i = 1'b0;
        q.push_back(mk(32'h21, 8));
        send_run(32'h21, 8);
        valid_i = 1'b1; d_i = 32'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checks += 3;
            if (ready_o !== 1'b0) begin errs++; $display("FAIL bp_ready cyc%0d got %b exp 0", i, ready_o); end
            if (valid_o !== 1'b1) begin errs++; $display("FAIL bp_valid cyc%0d got %b exp 1", i, valid_o); end
            if (d_o !== held)     begin errs++; $display("FAIL bp_stable cyc%0d got %h exp %h", i, d_o, held); end
            @(posedge clk_i); #1;
        end
        ready_i = 1'b1;
        q.push_back(mk(32'd9, 8));
        send_word(32'd9, 1'b0);
        checks++;
        if (valid_o !== 1'b0) begin errs++; $display("FAIL overlap_state valid_o got %b exp 0", valid_o); end
        send_run(32'd10, 7);
        wait_drained();
    endtask

    task automatic test_flush();
        ready_i = 1'b0;
        q.push_back(mk(32'hA, 3));
        send_run(32'hA, 3);
        pulse_flush();
        checks += 2;
        if (valid_o !== 1'b1) begin errs++; $display("FAIL flush_valid got %b exp 1", valid_o); end
        if (cnt_o !== 4'd3)   begin errs++; $display("FAIL flush_cnt got %0d exp 3", cnt_o); end
        ready_i = 1'b1;
        wait_drained();
        // Flush coinciding with an accepted word includes that word.
        q.push_back(mk(32'h31, 2));
        send_word(32'h31, 1'b0);
        send_word(32'h32, 1'b1);
        checks++;
        if (cnt_o !== 4'd2) begin errs++; $display("FAIL flush_acc_cnt got %0d exp 2", cnt_o); end
        wait_drained();
        // Flush on the completing word yields a single full frame.
        q.push_back(mk(32'h61, 8));
        send_run(32'h61, 7);
        send_word(32'h68, 1'b1);
        checks++;
        if (cnt_o !== 4'd8) begin errs++; $display("FAIL flush_full_cnt got %0d exp 8", cnt_o); end
        wait_drained();
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (valid_o !== 1'b0) begin errs++; $display("FAIL flush_full_extra valid_o got %b exp 0", valid_o); end
    endtask

    task automatic test_flush_ignored();
        logic [W*D-1:0] held;
        ready_i = 1'b1;
        pulse_flush();
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (valid_o !== 1'b0) begin errs++; $display("FAIL empty_flush valid_o got %b exp 0", valid_o); end
        held = pack(32'h41, 8);
        ready_i = 1'b0;
        q.push_back(mk(32'h41, 8));
        send_run(32'h41, 8);
        pulse_flush();
        checks += 3;
        if (valid_o !== 1'b1) begin errs++; $display("FAIL hold_flush_valid got %b exp 1", valid_o); end
        if (cnt_o !== 4'd8)   begin errs++; $display("FAIL hold_flush_cnt got %0d exp 8", cnt_o); end
        if (d_o !== held)     begin errs++; $display("FAIL hold_flush_data got %h exp %h", d_o, held); end
        ready_i = 1'b1;
        wait_drained();
    endtask

    task automatic test_reset_midframe();
        ready_i = 1'b1;
        send_run(32'h51, 4);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        q.push_back(mk(32'h11, 8));
        send_run(32'h11, 8);
        wait_drained();
        // A held frame is dropped by reset even while the sink is ready.
        ready_i = 1'b0;
        send_run(32'h71, 8);
        ready_i = 1'b1; rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0) begin errs++; $display("FAIL reset_drop valid_o got %b exp 0", valid_o); end
        q.push_back(mk(32'h81, 8));
        send_run(32'h81, 8);
        wait_drained();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_flush();
        test_flush_ignored();
        test_reset_midframe();
        repeat (3) @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
